// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath widths, shift op-codes and a bit-reverse helper.
package alu_pkg;

    localparam int WIDTH       = 32;
    localparam int SHIFT_WIDTH = 5;
    localparam int OPS         = 2;

    typedef enum logic [OPS-1:0] {
        LEFT_SHIFTL  = 2'b00,
        LEFT_SHIFTA  = 2'b01,
        RIGHT_SHIFTL = 2'b10,
        RIGHT_SHIFTA = 2'b11
    } shift_op_t;

    // Mirror a word end-for-end so a right-shift network can perform left shifts.
    function automatic logic [WIDTH-1:0] bit_reverse(input logic [WIDTH-1:0] value);
        logic [WIDTH-1:0] reversed;
        for (int i = 0; i < WIDTH; i++) begin
            reversed[i] = value[WIDTH-1-i];
        end
        return reversed;
    endfunction

endpackage

// File: rtl/shift_core.sv
// Stateless log-depth shifter: five right-shift stages of 1/2/4/8/16 bits.
// Left shifts reverse the operand on the way in and out of the network,
// so only one set of stage muxes is needed for both directions.
module shift_core
    import alu_pkg::*;
(
    input  logic [WIDTH-1:0]       data,
    input  logic [SHIFT_WIDTH-1:0] shift,
    input  logic [OPS-1:0]         op,
    output logic [WIDTH-1:0]       shifted
);

    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    logic             is_left;
    logic             fill_bit;
    logic [WIDTH-1:0] stage [SHIFT_WIDTH+1];

    // Orient the operand, then let each shift bit enable one fixed-distance stage with sign or zero fill.
    always_comb begin
        is_left  = (op == LEFT_SHIFTL) || (op == LEFT_SHIFTA);
        fill_bit = (op == RIGHT_SHIFTA) ? data[WIDTH-1] : 1'b0;
        stage[0] = is_left ? bit_reverse(data) : data;
        for (int s = 0; s < SHIFT_WIDTH; s++) begin
            if (shift[s]) begin
                stage[s+1] = (stage[s] >> (1 << s))
                           | ({WIDTH{fill_bit}} & ~(ALL_ONES >> (1 << s)));
            end else begin
                stage[s+1] = stage[s];
            end
        end
        shifted = is_left ? bit_reverse(stage[SHIFT_WIDTH]) : stage[SHIFT_WIDTH];
    end

endmodule

// File: rtl/barrel_shifter.sv
// ALU shift unit: samples operands on start, registers the shifted value
// and pulses valid for one cycle for every accepted request.
module barrel_shifter
    import alu_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       data,
    input  logic [SHIFT_WIDTH-1:0] shift,
    input  logic [OPS-1:0]         op,
    input  logic                   start,
    output logic [WIDTH-1:0]       result,
    output logic                   valid
);

    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] result_d, result_q;
    logic             valid_d, valid_q;

    shift_core u_shift_core (
        .data    (data),
        .shift   (shift),
        .op      (op),
        .shifted (shifted)
    );

    // Capture a new result only on start; otherwise hold it and drop valid.
    always_comb begin
        result_d = start ? shifted : result_q;
        valid_d  = start;
    end

    // Output registers, cleared immediately when reset is asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

    assign result = result_q;
    assign valid  = valid_q;

endmodule

// File: tb/tb_barrel_shifter.sv
// Scoreboard bench for barrel_shifter: stimulus pushes expected results,
// a monitor pops and compares whenever valid is presented.
module tb_barrel_shifter;
    import alu_pkg::*;

    logic                   clk;
    logic                   rst_n;
    logic [WIDTH-1:0]       data;
    logic [SHIFT_WIDTH-1:0] shift;
    logic [OPS-1:0]         op;
    logic                   start;
    logic [WIDTH-1:0]       result;
    logic                   valid;

    logic [31:0] expected_q[$];
    int          checks = 0;
    int          errors = 0;

    barrel_shifter dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .data   (data),
        .shift  (shift),
        .op     (op),
        .start  (start),
        .result (result),
        .valid  (valid)
    );

    // Free-running clock, period 10
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one value and report a mismatch
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, required);
        end
    endtask

    // Drive one request at a falling edge and queue its expected result
    task automatic applyStimulus(input logic [31:0] d, input logic [4:0] s, input logic [1:0] o, input logic [31:0] exp_val);
        @(negedge clk);
        data  = d;
        shift = s;
        op    = o;
        start = 1'b1;
        expected_q.push_back(exp_val);
    endtask

    // Reference shift behaviour using the language operators
    function automatic logic [31:0] refShift(input logic [31:0] d, input logic [4:0] s, input logic [1:0] o);
        logic signed [31:0] sd;
        sd = d;
        case (o)
            2'b00:   return d << s;
            2'b01:   return sd <<< s;
            2'b10:   return d >> s;
            default: return sd >>> s;
        endcase
    endfunction

    // Monitor: pop and compare whenever the DUT presents a result
    initial begin
        logic [31:0] exp_val;
        forever begin
            @(negedge clk);
            if (valid === 1'b1) begin
                if (expected_q.size() == 0) begin
                    checkOutput("unexpected_valid", result, 32'h0);
                    errors += (result === 32'h0) ? 1 : 0;
                end else begin
                    exp_val = expected_q.pop_front();
                    checkOutput("scoreboard_result", result, exp_val);
                end
            end
        end
    end

    // Watchdog so the run always terminates
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "[TB] watchdog expired");
    end

    // Main stimulus sequence
    initial begin
        logic [31:0] d;
        logic [4:0]  s;
        logic [1:0]  o;

        rst_n = 1'b0;
        start = 1'b1;
        data  = 32'hFFFFFFFF;
        shift = 5'd0;
        op    = 2'b00;

        // Reset held with start high: outputs must stay clear
        repeat (2) @(negedge clk);
        checkOutput("reset_result", result, 32'h0);
        checkOutput("reset_valid", {31'b0, valid}, 32'h0);

        // Release reset with start low: no update until a start edge
        start = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("post_reset_result", result, 32'h0);
        checkOutput("post_reset_valid", {31'b0, valid}, 32'h0);

        // Directed vectors, issued back-to-back
        applyStimulus(32'h80000000, 5'd4,  RIGHT_SHIFTA, 32'hF8000000);
        applyStimulus(32'h80000000, 5'd4,  RIGHT_SHIFTL, 32'h08000000);
        applyStimulus(32'h80000001, 5'd1,  LEFT_SHIFTL,  32'h00000002);
        applyStimulus(32'h80000001, 5'd1,  LEFT_SHIFTA,  32'h00000002);
        applyStimulus(32'h80000001, 5'd31, LEFT_SHIFTL,  32'h80000000);
        applyStimulus(32'h80000001, 5'd31, LEFT_SHIFTA,  32'h80000000);
        applyStimulus(32'h80000001, 5'd31, RIGHT_SHIFTL, 32'h00000001);
        applyStimulus(32'h80000001, 5'd31, RIGHT_SHIFTA, 32'hFFFFFFFF);
        applyStimulus(32'h12345678, 5'd0,  LEFT_SHIFTL,  32'h12345678);
        applyStimulus(32'h12345678, 5'd0,  LEFT_SHIFTA,  32'h12345678);
        applyStimulus(32'h12345678, 5'd0,  RIGHT_SHIFTL, 32'h12345678);
        applyStimulus(32'h12345678, 5'd0,  RIGHT_SHIFTA, 32'h12345678);
        applyStimulus(32'h7FFFFFFF, 5'd31, RIGHT_SHIFTA, 32'h00000000);
        applyStimulus(32'hF0000000, 5'd12, RIGHT_SHIFTL, 32'h000F0000);
        @(negedge clk);
        start = 1'b0;

        // Throughput: three consecutive starts keep valid high every cycle
        applyStimulus(32'hA5A5A5A5, 5'd8,  RIGHT_SHIFTL, 32'h00A5A5A5);
        applyStimulus(32'h0F0F0000, 5'd4,  LEFT_SHIFTL,  32'hF0F00000);
        checkOutput("b2b_valid_1", {31'b0, valid}, 32'h1);
        applyStimulus(32'h80F00000, 5'd20, RIGHT_SHIFTA, 32'hFFFFF80F);
        checkOutput("b2b_valid_2", {31'b0, valid}, 32'h1);
        checkOutput("b2b_result_2", result, 32'hF0F00000);
        @(negedge clk);
        start = 1'b0;
        checkOutput("b2b_valid_3", {31'b0, valid}, 32'h1);
        checkOutput("b2b_result_3", result, 32'hFFFFF80F);

        // Start low: result holds, valid drops
        data = 32'h0;
        repeat (2) begin
            @(negedge clk);
            checkOutput("hold_result", result, 32'hFFFFF80F);
            checkOutput("hold_valid", {31'b0, valid}, 32'h0);
        end

        // Reset asserted mid-request: pending sample is discarded at once
        @(negedge clk);
        data  = 32'hDEADBEEF;
        shift = 5'd3;
        op    = LEFT_SHIFTL;
        start = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_result", result, 32'h0);
        checkOutput("async_reset_valid", {31'b0, valid}, 32'h0);
        @(negedge clk);
        checkOutput("in_reset_result", result, 32'h0);
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("after_reset_valid", {31'b0, valid}, 32'h0);

        // Random operands across all four ops
        for (int i = 0; i < 32; i++) begin
            d = $urandom;
            s = 5'($urandom_range(0, 31));
            o = 2'(i % 4);
            applyStimulus(d, s, o, refShift(d, s, o));
        end
        @(negedge clk);
        start = 1'b0;

        // Every queued expectation must have been matched by a valid
        repeat (3) @(negedge clk);
        checkOutput("scoreboard_drain", 32'(expected_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/barrel_shifter.md
Name: barrel_shifter

Overview:
- 32-bit, four-mode barrel shifter (logical/arithmetic, left/right) used as the shift unit of the ALU datapath.
- Operand, shift amount and op are sampled on a clock edge when start is high.
- The shifted result is registered and held until the next accepted start.
- Arithmetic core is a log-depth mux network; the wrapper adds input qualification and output registers.

Parameters:
- WIDTH, 32, data/result width in bits.
- SHIFT_WIDTH, 5, shift-amount width; must equal clog2(WIDTH).
- OPS, 2, op-code width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- data  input  WIDTH  operand to shift.
- shift  input  SHIFT_WIDTH  shift amount, unsigned 0..WIDTH-1.
- op  input  OPS  operation select: LEFT_SHIFTL, LEFT_SHIFTA, RIGHT_SHIFTL, RIGHT_SHIFTA.
- start  input  1  request strobe; inputs are sampled on rising clk when high.
- result  output  WIDTH  registered shifted value.
- valid  output  1  one-cycle pulse marking a newly updated result.

Behaviour:
- Reset: rst_n low asynchronously forces result=0 and valid=0, regardless of clk.
- First accept after reset release is the first rising clk with start=1.
- Op encodings:
  - 2'b00 LEFT_SHIFTL
  - 2'b01 LEFT_SHIFTA
  - 2'b10 RIGHT_SHIFTL
  - 2'b11 RIGHT_SHIFTA
- LEFT_SHIFTL: data << shift, zero fill from the LSB.
- LEFT_SHIFTA: identical to LEFT_SHIFTL (zero fill; sign bit is not preserved), matching Verilog signed <<<.
- RIGHT_SHIFTL: data >> shift, zero fill from the MSB.
- RIGHT_SHIFTA: $signed(data) >>> shift, filling vacated MSBs with data[WIDTH-1].
- Latency: inputs sampled at rising edge N with start=1 appear on result after edge N; valid=1 for the cycle following edge N.
- Start low: result holds its previous value and valid=0.
- Back-to-back: start high on consecutive edges updates result every cycle and keeps valid high continuously. Full throughput, no busy state, no backpressure.
- shift=0: result equals data for all ops.
- shift=WIDTH-1 boundary:
  - Left ops: result = {data[0], 31 zeros}.
  - RIGHT_SHIFTL: result = {31 zeros, data[31]}.
  - RIGHT_SHIFTA: all bits equal data[31].
- Shift amounts >= WIDTH are unrepresentable at SHIFT_WIDTH=5; no saturation logic is needed.
- Reset asserted mid-operation: the pending sample is discarded; result=0 and valid=0 immediately.
- X/undefined op is not required to be handled. All four 2-bit codes are legal, so no error output.
- Core is purely combinational:
  - 5 stages shifting by 1, 2, 4, 8, 16, each selected by one shift bit.
  - Fill bit = data[WIDTH-1] for RIGHT_SHIFTA, else 0.
  - Direction handled either by per-stage left/right muxing or by bit-reverse before and after a right-shift network; either is acceptable.

Decomposition:
- Shared package alu_pkg holds:
  - WIDTH, SHIFT_WIDTH, OPS;
  - op-code constants LEFT_SHIFTA, LEFT_SHIFTL, RIGHT_SHIFTA, RIGHT_SHIFTL (or an enum typedef shift_op_t).
- One sub-module, shift_core: combinational log shifter (data, shift, op -> shifted) with no state.
- barrel_shifter instantiates shift_core and owns the start qualification, result register and valid register.

Test Plan:
- Reset: hold rst_n=0 with start=1, data=32'hFFFFFFFF -> result=0, valid=0. Deassert rst_n -> first update occurs only on the next start edge.
- RIGHT_SHIFTA: data=32'h80000000, shift=4, start=1 -> next cycle result=32'hF8000000, valid=1. Same stimulus with RIGHT_SHIFTL -> result=32'h08000000.
- Left ops: data=32'h80000001, shift=1 -> LEFT_SHIFTL and LEFT_SHIFTA both give 32'h00000002. Same data with shift=31 -> 32'h80000000.
- Boundaries: data=32'h12345678, shift=0 -> all four ops return 32'h12345678. data=32'h7FFFFFFF, shift=31, RIGHT_SHIFTA -> 32'h00000000.
- Hold/throughput: start pulses on 3 consecutive edges with distinct data -> result changes every cycle and valid stays high. start then low -> result holds and valid=0.
- Random: 32 random data with shift=$random%32 across all ops -> compare each against Verilog <<, <<<, >> and $signed >>> one cycle after acceptance. Zero mismatches.
